// File: rtl/mpc_qp_admm_zk_update.sv
// ADMM z-update engine: streams w[i], clamps each element to [zmin,zmax],
// writes the result to the zk vector RAM and tracks max |z_new - z_old|.
// Optional feature macro: MPC_ZK_RESIDUAL_EN (old-z read and residual tracking).
// Without it, zk port1 stays idle and ap_return is constantly 0.
// DATA_W / ADDR_W / VEC_LEN correspond to DataWidth / AddressWidth / VecLen.
module mpc_qp_admm_zk_update #(
  parameter int DATA_W  = 21,
  parameter int ADDR_W  = 5,
  parameter int VEC_LEN = 18
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     ap_start,
  output logic                     ap_done,
  output logic                     ap_idle,
  output logic                     ap_ready,
  input  logic signed [DATA_W-1:0] zmin,
  input  logic signed [DATA_W-1:0] zmax,
  output logic [ADDR_W-1:0]        w_address0,
  output logic                     w_ce0,
  input  logic signed [DATA_W-1:0] w_q0,
  output logic [ADDR_W-1:0]        zk_address0,
  output logic                     zk_ce0,
  output logic                     zk_we0,
  output logic signed [DATA_W-1:0] zk_d0,
  output logic [ADDR_W-1:0]        zk_address1,
  output logic                     zk_ce1,
  output logic                     zk_we1,
  output logic signed [DATA_W-1:0] zk_d1,
  input  logic signed [DATA_W-1:0] zk_q1,
  output logic [DATA_W-1:0]        ap_return
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [ADDR_W-1:0]          k;
  logic                       vld_p1, vld_p2;
  logic                       start_go;
  logic signed [DATA_W-1:0]   zmin_q, zmax_q;
  logic [ADDR_W-1:0]          addr_p1, addr_p2;
  logic signed [DATA_W-1:0]   z_p2;

  // Upper bound applied first, then lower bound, so zmin wins when zmin > zmax.
  function automatic logic signed [DATA_W-1:0] clamp(
    input logic signed [DATA_W-1:0] w,
    input logic signed [DATA_W-1:0] lo,
    input logic signed [DATA_W-1:0] hi
  );
    logic signed [DATA_W-1:0] z;
    z = (w > hi) ? hi : w;
    z = (z < lo) ? lo : z;
    return z;
  endfunction

  assign start_go = ((state == IDLE) || (state == DONE)) && ap_start;

  // Next-state decode and control outputs.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ap_start) state_nxt = RUN;
      RUN:     if (k == K_LAST) state_nxt = DRAIN;
      // Once the capture stage is empty, the output stage finishes its last write this cycle.
      DRAIN:   if (!vld_p1) state_nxt = DONE;
      DONE:    state_nxt = ap_start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ap_idle    = (state == IDLE);
  assign ap_done    = (state == DONE);
  assign ap_ready   = (state == DONE);
  assign w_ce0      = (state == RUN);
  assign w_address0 = k;

  // Control state: FSM, element counter and pipeline valids.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= IDLE;
      k      <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= (state == RUN);
      vld_p2 <= vld_p1;
      if (state == RUN) k <= (k == K_LAST) ? '0 : k + ADDR_W'(1);
      else              k <= '0;
    end
  end

  // Bounds latch and datapath pipeline (no reset on data).
  always_ff @(posedge ap_clk) begin
    if (start_go) begin
      zmin_q <= zmin;
      zmax_q <= zmax;
    end
    // p1: read data arrives for the address issued last cycle
    addr_p1 <= k;
    // p2: clamped result registered toward the zk write port
    addr_p2 <= addr_p1;
    z_p2    <= clamp(w_q0, zmin_q, zmax_q);
  end

  assign zk_ce0      = vld_p2;
  assign zk_we0      = vld_p2;
  assign zk_address0 = vld_p2 ? addr_p2 : '0;
  assign zk_d0       = vld_p2 ? z_p2 : '0;
  assign zk_we1      = 1'b0;
  assign zk_d1       = '0;

`ifdef MPC_ZK_RESIDUAL_EN
  localparam logic [DATA_W:0] MAG_MAX = {2'b00, {(DATA_W-1){1'b1}}};

  logic signed [DATA_W-1:0] zold_p2;
  logic [DATA_W-1:0]        res;
  logic [DATA_W-1:0]        dz_p2;

  // |a - b| at DATA_W+1 bits, saturated to the largest positive DATA_W value.
  function automatic logic [DATA_W-1:0] abs_diff_sat(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] d;
    logic [DATA_W:0]        mag;
    d   = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    mag = d[DATA_W] ? $unsigned(-d) : $unsigned(d);
    return (mag > MAG_MAX) ? MAG_MAX[DATA_W-1:0] : mag[DATA_W-1:0];
  endfunction

  assign zk_ce1      = (state == RUN);
  assign zk_address1 = k;
  assign dz_p2       = abs_diff_sat(z_p2, zold_p2);
  assign ap_return   = res;

  // Old z follows its element into the output stage.
  always_ff @(posedge ap_clk) begin
    zold_p2 <= zk_q1;
  end

  // Running max residual, cleared when a pass starts.
  always_ff @(posedge ap_clk) begin
    if (ap_rst)                      res <= '0;
    else if (start_go)               res <= '0;
    else if (vld_p2 && (dz_p2 > res)) res <= dz_p2;
  end
`else
  logic unused_zk_q1;

  assign unused_zk_q1 = ^zk_q1;
  assign zk_ce1       = 1'b0;
  assign zk_address1  = '0;
  assign ap_return    = '0;
`endif

endmodule
